// File: rtl/dmem_priv_bus_seq.sv
// Data-memory private-bus sequencer.
// Takes one DCache request (optional write phase followed by optional read phase),
// splits each phase into BUS_W-wide beats on the private bus, collects read data and
// reports per-phase completion. A per-beat WAIT timeout forces an error termination.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 request from DCache, sampled only when idle
//   read_abort            cancels the pending or ongoing read phase
//   full_start_in/_out    full-bus burst start, passed only while idle and not requesting
//   busy                  sequencer not idle
//   wr_done/rd_done/err   phase completion pulses, err qualifies them
//   rd_data               assembled read data
//   bus_*                 private-bus beat interface
module dmem_priv_bus_seq #(
    parameter int unsigned BUS_W     = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BEATS = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic                         req_read,
    input  logic [$clog2(MAX_BEATS):0]   req_wbeats,
    input  logic [$clog2(MAX_BEATS):0]   req_rbeats,
    input  logic [ADDR_W-1:0]            req_waddr,
    input  logic [ADDR_W-1:0]            req_raddr,
    input  logic [BUS_W*MAX_BEATS-1:0]   req_wdata,
    input  logic                         read_abort,
    input  logic                         full_start_in,
    output logic                         full_start_out,
    output logic                         busy,
    output logic                         wr_done,
    output logic                         rd_done,
    output logic                         err,
    output logic [BUS_W*MAX_BEATS-1:0]   rd_data,
    output logic                         bus_start,
    output logic                         bus_write,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [BUS_W-1:0]             bus_wdata,
    input  logic                         bus_ack,
    input  logic                         bus_err,
    input  logic [BUS_W-1:0]             bus_rdata
);
    localparam int unsigned CW = $clog2(MAX_BEATS) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned DW = BUS_W * MAX_BEATS;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            r_state, w_state_d;
    logic              r_phase_wr, w_phase_wr_d;
    logic              r_rd_pend, w_rd_pend_d;
    logic              r_abort, w_abort_d;
    logic [CW-1:0]     r_beat, w_beat_d;
    logic [CW-1:0]     r_nbeats, w_nbeats_d;
    logic [CW-1:0]     r_rbeats, w_rbeats_d;
    logic [TW-1:0]     r_tcnt, w_tcnt_d;
    logic [ADDR_W-1:0] r_waddr, w_waddr_d;
    logic [ADDR_W-1:0] r_raddr, w_raddr_d;
    logic [DW-1:0]     r_wdata, w_wdata_d;
    logic [DW-1:0]     r_rd_data, w_rd_data_d;
    logic              r_wr_done, w_wr_done_d;
    logic              r_rd_done, w_rd_done_d;
    logic              r_err, w_err_d;

    logic              w_busy, w_accept, w_tout, w_end, w_fail, w_last, w_rd_killed;
    logic [BUS_W-1:0]  w_bus_wdata;

    assign w_busy      = (r_state != StIdle);
    assign w_accept    = (r_state == StIdle) & req_valid & (req_write | req_read);
    // Final WAIT cycle without an ack counts as an errored ack.
    assign w_tout      = (r_state == StWait) & ~bus_ack & (r_tcnt == TW'(TIMEOUT - 1));
    assign w_end       = (r_state == StWait) & (bus_ack | w_tout);
    assign w_fail      = w_tout | (bus_ack & bus_err);
    assign w_last      = ({1'b0, r_beat} + (CW + 1)'(1)) >= {1'b0, r_nbeats};
    // A registered abort stops the read phase before any further beat is issued.
    assign w_rd_killed = ~r_phase_wr & r_abort;

    always_comb begin
        w_bus_wdata = '0;
        for (int i = 0; i < int'(MAX_BEATS); i++) begin
            if (r_beat == CW'(i)) w_bus_wdata = r_wdata[i*BUS_W +: BUS_W];
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_phase_wr_d = r_phase_wr;
        w_rd_pend_d  = r_rd_pend;
        w_abort_d    = r_abort | (read_abort & w_busy);
        w_beat_d     = r_beat;
        w_nbeats_d   = r_nbeats;
        w_rbeats_d   = r_rbeats;
        w_tcnt_d     = r_tcnt;
        w_waddr_d    = r_waddr;
        w_raddr_d    = r_raddr;
        w_wdata_d    = r_wdata;
        w_rd_data_d  = r_rd_data;
        w_wr_done_d  = 1'b0;
        w_rd_done_d  = 1'b0;
        w_err_d      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_phase_wr_d = req_write;
                    w_rd_pend_d  = req_read;
                    w_beat_d     = '0;
                    w_nbeats_d   = req_write ? req_wbeats : req_rbeats;
                    w_rbeats_d   = req_rbeats;
                    w_waddr_d    = req_waddr;
                    w_raddr_d    = req_raddr;
                    w_wdata_d    = req_wdata;
                    w_state_d    = StIssue;
                end
            end
            StIssue: begin
                w_tcnt_d  = '0;
                w_state_d = w_rd_killed ? StIdle : StWait;
            end
            StWait: begin
                if (w_end) begin
                    if (bus_ack & ~r_phase_wr) begin
                        for (int i = 0; i < int'(MAX_BEATS); i++) begin
                            if (r_beat == CW'(i)) w_rd_data_d[i*BUS_W +: BUS_W] = bus_rdata;
                        end
                    end
                    if (w_fail) begin
                        w_state_d = StIdle;
                        if (r_phase_wr) begin
                            // The pending read is reported as failed together with the write.
                            w_wr_done_d = 1'b1;
                            w_err_d     = 1'b1;
                            w_rd_done_d = r_rd_pend & ~r_abort;
                        end else if (~r_abort) begin
                            w_rd_done_d = 1'b1;
                            w_err_d     = 1'b1;
                        end
                    end else if (~w_last) begin
                        w_beat_d  = r_beat + CW'(1);
                        w_state_d = w_rd_killed ? StIdle : StIssue;
                    end else if (r_phase_wr) begin
                        w_wr_done_d = 1'b1;
                        if (r_rd_pend & ~r_abort) begin
                            w_phase_wr_d = 1'b0;
                            w_beat_d     = '0;
                            w_nbeats_d   = r_rbeats;
                            w_state_d    = StIssue;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_rd_done_d = ~r_abort;
                        w_state_d   = StIdle;
                    end
                end else begin
                    w_tcnt_d = r_tcnt + TW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_state_d == StIdle) w_abort_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_phase_wr <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_abort    <= 1'b0;
            r_beat     <= '0;
            r_nbeats   <= '0;
            r_rbeats   <= '0;
            r_tcnt     <= '0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_wr_done  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_phase_wr <= w_phase_wr_d;
            r_rd_pend  <= w_rd_pend_d;
            r_abort    <= w_abort_d;
            r_beat     <= w_beat_d;
            r_nbeats   <= w_nbeats_d;
            r_rbeats   <= w_rbeats_d;
            r_tcnt     <= w_tcnt_d;
            r_waddr    <= w_waddr_d;
            r_raddr    <= w_raddr_d;
            r_wdata    <= w_wdata_d;
            r_rd_data  <= w_rd_data_d;
            r_wr_done  <= w_wr_done_d;
            r_rd_done  <= w_rd_done_d;
            r_err      <= w_err_d;
        end
    end

    assign busy           = w_busy;
    assign wr_done        = r_wr_done;
    assign rd_done        = r_rd_done;
    assign err            = r_err;
    assign rd_data        = r_rd_data;
    assign bus_start      = (r_state == StIssue) & ~w_rd_killed;
    assign bus_write      = w_busy & r_phase_wr;
    assign bus_addr       = (r_phase_wr ? r_waddr : r_raddr)
                          + ADDR_W'(r_beat) * ADDR_W'(BUS_W / 8);
    assign bus_wdata      = w_bus_wdata;
    assign full_start_out = full_start_in & ~w_busy & ~(req_valid & (req_write | req_read));

endmodule

// File: tb/tb_dmem_priv_bus_seq.sv
module tb_dmem_priv_bus_seq;
    localparam int BUS_W     = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_BEATS = 2;
    localparam int TIMEOUT   = 4;
    localparam int BW        = $clog2(MAX_BEATS) + 1;
    localparam int NC        = 3000;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req_valid, req_write, req_read;
    logic [BW-1:0]          req_wbeats, req_rbeats;
    logic [ADDR_W-1:0]      req_waddr, req_raddr;
    logic [63:0]            req_wdata;
    logic                   read_abort, full_start_in, full_start_out;
    logic                   busy, wr_done, rd_done, err;
    logic [63:0]            rd_data;
    logic                   bus_start, bus_write;
    logic [ADDR_W-1:0]      bus_addr;
    logic [BUS_W-1:0]       bus_wdata;
    logic                   bus_ack, bus_err;
    logic [BUS_W-1:0]       bus_rdata;

    always #5 clk = ~clk;

    dmem_priv_bus_seq #(
        .BUS_W(BUS_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_read(req_read),
        .req_wbeats(req_wbeats), .req_rbeats(req_rbeats),
        .req_waddr(req_waddr), .req_raddr(req_raddr), .req_wdata(req_wdata),
        .read_abort(read_abort), .full_start_in(full_start_in), .full_start_out(full_start_out),
        .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .err(err), .rd_data(rd_data),
        .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    // Per-cycle stimulus and expected outputs, built up front by the transaction model.
    logic          s_rv[NC], s_rw[NC], s_rr[NC], s_ab[NC], s_fs[NC], s_ack[NC], s_berr[NC];
    logic [BW-1:0] s_wb[NC], s_rb[NC];
    logic [31:0]   s_wa[NC], s_ra[NC], s_rdat[NC];
    logic [63:0]   s_wd[NC];
    logic          x_busy[NC], x_bst[NC], x_bval[NC], x_bw[NC], x_wdv[NC];
    logic          x_wrd[NC], x_rdd[NC], x_err[NC], x_fso[NC];
    logic [31:0]   x_addr[NC], x_wdat[NC];
    logic [63:0]   x_rdat[NC];
    int            x_rdk[NC];

    int            p_lat[4];
    logic          p_err[4];
    logic [31:0]   p_rdv[4];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cur = 0;
    bit            chk_en = 1'b0;

    task automatic chk(input string nm, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    // Transaction model: a = acceptance cycle, x = read_abort cycle (-1 none).
    // Beat g (0..1 write, 2..3 read) is acked p_lat cycles after its start; a latency
    // beyond TIMEOUT ends the beat with an error after TIMEOUT WAIT cycles.
    task automatic plan_txn(input int a, input bit rw, input bit rr, input int wb, input int rb,
                            input logic [31:0] wa, input logic [31:0] ra,
                            input logic [63:0] wd, input int x, output int d);
        int c, e, k, nb, g, lim;
        bit wr, fail, ab;
        s_rv[a] = 1'b1; s_rw[a] = rw; s_rr[a] = rr;
        s_wb[a] = BW'(wb); s_rb[a] = BW'(rb);
        s_wa[a] = wa; s_ra[a] = ra; s_wd[a] = wd;
        if (x >= 0) s_ab[x] = 1'b1;
        wr = rw; k = 0; nb = rw ? wb : rb; c = a + 1; d = c;
        forever begin
            g   = (wr ? 0 : MAX_BEATS) + k;
            lim = (p_lat[g] > TIMEOUT) ? TIMEOUT : p_lat[g];
            e   = c + lim;
            for (int t = c; t <= e; t++) begin
                x_busy[t] = 1'b1; x_bval[t] = 1'b1; x_bw[t] = wr; x_wdv[t] = wr;
                x_addr[t] = (wr ? wa : ra) + 32'(k * (BUS_W / 8));
                x_wdat[t] = 32'(wd >> (k * BUS_W));
            end
            x_bst[c] = 1'b1;
            ab = (x >= a + 1) && (x < e);
            if (p_lat[g] <= TIMEOUT) begin
                s_ack[e] = 1'b1; s_berr[e] = p_err[g]; s_rdat[e] = p_rdv[g];
                if (!wr) x_rdk[e] = k;
                fail = p_err[g];
            end else begin
                s_ack[e+1] = 1'b1; s_berr[e+1] = 1'($urandom_range(0, 1));
                s_rdat[e+1] = $urandom;
                fail = 1'b1;
            end
            d = e + 1;
            if (fail) begin
                if (wr) begin
                    x_wrd[d] = 1'b1; x_err[d] = 1'b1;
                    if (rr && !ab) x_rdd[d] = 1'b1;
                end else if (!ab) begin
                    x_rdd[d] = 1'b1; x_err[d] = 1'b1;
                end
                return;
            end
            if (k + 1 < nb) begin
                if (!wr && ab) return;
                k++; c = d;
            end else if (wr) begin
                x_wrd[d] = 1'b1;
                if (rr && !ab) begin
                    wr = 1'b0; k = 0; nb = rb; c = d;
                end else begin
                    return;
                end
            end else begin
                if (!ab) x_rdd[d] = 1'b1;
                return;
            end
        end
    endtask

    task automatic clear_p();
        for (int g = 0; g < 4; g++) begin
            p_lat[g] = 1; p_err[g] = 1'b0; p_rdv[g] = '0;
        end
    endtask

    task automatic apply(input int c);
        req_valid = s_rv[c]; req_write = s_rw[c]; req_read = s_rr[c];
        req_wbeats = s_wb[c]; req_rbeats = s_rb[c];
        req_waddr = s_wa[c]; req_raddr = s_ra[c]; req_wdata = s_wd[c];
        read_abort = s_ab[c]; full_start_in = s_fs[c];
        bus_ack = s_ack[c]; bus_err = s_berr[c]; bus_rdata = s_rdat[c];
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", cur, busy, x_busy[cur]);
            chk("bus_start", cur, bus_start, x_bst[cur]);
            chk("wr_done", cur, wr_done, x_wrd[cur]);
            chk("rd_done", cur, rd_done, x_rdd[cur]);
            chk("err", cur, err, x_err[cur]);
            chk("full_start_out", cur, full_start_out, x_fso[cur]);
            chk("rd_data", cur, rd_data, x_rdat[cur]);
            if (x_bval[cur]) begin
                chk("bus_write", cur, bus_write, x_bw[cur]);
                chk("bus_addr", cur, bus_addr, x_addr[cur]);
                if (x_wdv[cur]) chk("bus_wdata", cur, bus_wdata, x_wdat[cur]);
            end
            // Hand-computed anchors for the directed transactions.
            if (cur == 3)  chk("rd2_addr0", cur, {bus_start, bus_addr}, {1'b1, 32'h0000_1000});
            if (cur == 7)  chk("rd2_addr1", cur, {bus_start, bus_addr}, {1'b1, 32'h0000_1004});
            if (cur == 11) chk("rd2_data", cur, rd_data, 64'h12345678_AAAA5555);
            if (cur == 11) chk("rd2_done", cur, {rd_done, err}, 2'b10);
            if (cur == 12) chk("wr2_beat0", cur, {bus_write, bus_addr, bus_wdata},
                               {1'b1, 32'h0000_2000, 32'h0123_4567});
            if (cur == 15) chk("wr2_beat1", cur, {bus_write, bus_addr, bus_wdata},
                               {1'b1, 32'h0000_2004, 32'hDEAD_BEEF});
            if (cur == 18) chk("wr2_to_rd", cur, {wr_done, bus_start, bus_write}, 3'b110);
            if (cur == 21) chk("wr2rd1_done", cur, {rd_done, err, busy}, 3'b100);
            if (cur == 26) chk("abort_wr_done", cur, {wr_done, rd_done, busy}, 3'b100);
            if (cur == 27) chk("abort_no_rd", cur, {bus_start, busy}, 2'b00);
            if (cur == 32) chk("err_both_done", cur, {wr_done, rd_done, err, busy}, 4'b1110);
            if (cur == 38) chk("tout_wait4", cur, {rd_done, busy}, 2'b01);
            if (cur == 39) chk("tout_done", cur, {rd_done, err, busy}, 3'b110);
            if (cur == 36) chk("fso_busy", cur, full_start_out, 1'b0);
            if (cur == 40) chk("fso_idle", cur, full_start_out, 1'b1);
        end
    end

    int          a, d, lastc, mode, sel, x, gap;
    bit          rw, rr;
    logic [31:0] wa, ra;
    logic [63:0] wd, rdm;

    initial begin
        for (int c = 0; c < NC; c++) begin
            s_rv[c] = 0; s_rw[c] = 0; s_rr[c] = 0; s_ab[c] = 0; s_fs[c] = 0;
            s_ack[c] = 0; s_berr[c] = 0; s_wb[c] = '0; s_rb[c] = '0;
            s_wa[c] = '0; s_ra[c] = '0; s_rdat[c] = '0; s_wd[c] = '0;
            x_busy[c] = 0; x_bst[c] = 0; x_bval[c] = 0; x_bw[c] = 0; x_wdv[c] = 0;
            x_wrd[c] = 0; x_rdd[c] = 0; x_err[c] = 0; x_fso[c] = 0;
            x_addr[c] = '0; x_wdat[c] = '0; x_rdat[c] = '0; x_rdk[c] = -1;
        end

        // Two-beat read with fixed 3-cycle acks.
        clear_p(); p_lat[2] = 3; p_lat[3] = 3; p_rdv[2] = 32'hAAAA5555; p_rdv[3] = 32'h12345678;
        plan_txn(2, 0, 1, 1, 2, 32'h0, 32'h1000, 64'h0, -1, d);
        // Write 2 + read 1.
        clear_p(); p_lat[0] = 2; p_lat[1] = 2; p_lat[2] = 2; p_rdv[2] = 32'h5A5A_0F0F;
        plan_txn(11, 1, 1, 2, 1, 32'h2000, 32'h3000, 64'hDEADBEEF_01234567, -1, d);
        // Write 1 + read 2 with abort during write WAIT.
        clear_p(); p_lat[0] = 3;
        plan_txn(21, 1, 1, 1, 2, 32'h4000, 32'h4800, 64'h1111_2222_3333_4444, 23, d);
        // Error on write beat 0 of 2 with read pending.
        clear_p(); p_lat[0] = 2; p_err[0] = 1'b1;
        plan_txn(28, 1, 1, 2, 1, 32'h5000, 32'h5800, 64'h5555_6666_7777_8888, -1, d);
        // Read with no ack until after timeout.
        clear_p(); p_lat[2] = 9;
        plan_txn(33, 0, 1, 1, 1, 32'h0, 32'h6000, 64'h0, -1, d);
        for (int c = 33; c <= 41; c++) s_fs[c] = 1'b1;

        a = 42;
        while (a < NC - 80) begin
            mode = $urandom_range(0, 2);
            rw = (mode != 1); rr = (mode != 0);
            wa = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom;
            ra = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom;
            wd = {$urandom, $urandom};
            for (int g = 0; g < 4; g++) begin
                p_lat[g] = $urandom_range(1, 5);
                p_err[g] = ($urandom_range(0, 9) == 0);
                p_rdv[g] = $urandom;
            end
            sel = $urandom_range(0, 9);
            x = (sel < 2) ? a : ((sel < 4) ? a + 1 : -1);
            plan_txn(a, rw, rr, $urandom_range(1, 2), $urandom_range(1, 2), wa, ra, wd, x, d);
            for (int t = a + 1; t < d; t++) begin
                s_rv[t] = 1'($urandom_range(0, 1)); s_rw[t] = 1'($urandom_range(0, 1));
                s_rr[t] = 1'($urandom_range(0, 1)); s_wb[t] = BW'($urandom_range(0, 3));
                s_wa[t] = $urandom; s_ra[t] = $urandom; s_wd[t] = {$urandom, $urandom};
            end
            gap = $urandom_range(0, 3);
            for (int t = d; t < d + gap; t++) begin
                s_rv[t] = 1'($urandom_range(0, 1));
                s_ab[t] = s_ab[t] | 1'($urandom_range(0, 1));
                s_ack[t] = s_ack[t] | 1'($urandom_range(0, 1));
            end
            for (int t = a; t < d + gap; t++) s_fs[t] = 1'($urandom_range(0, 1));
            a = d + gap;
        end
        lastc = a + 4;

        rdm = '0;
        for (int c = 0; c < NC; c++) begin
            x_rdat[c] = rdm;
            if (x_rdk[c] >= 0) rdm[x_rdk[c]*BUS_W +: BUS_W] = s_rdat[c];
            x_fso[c] = s_fs[c] & ~x_busy[c] & ~(s_rv[c] & (s_rw[c] | s_rr[c]));
        end

        apply(0);
        full_start_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", -1, {busy, wr_done, rd_done, err, bus_start, bus_write}, 6'b0);
        chk("rst_bus", -1, {bus_addr, bus_wdata}, 64'h0);
        chk("rst_rd_data", -1, rd_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c <= lastc; c++) begin
            @(posedge clk);
            #1;
            apply(c);
            cur = c;
            chk_en = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        // Reset in the middle of a read beat: abandoned, no done pulse afterwards.
        apply(NC - 1);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_rbeats = BW'(1); req_raddr = 32'h7000;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mr_busy_pre", -1, busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async", -1, {busy, bus_start, bus_write, rd_data}, 67'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            chk("mr_quiet", -1, {busy, wr_done, rd_done, err, rd_data}, 68'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
